// File: rtl/add_4.sv
// 4-bit ripple-carry adder built from four 1-bit full adders, with registered
// {cout, sum} and a registered two's-complement overflow flag.

module add_4_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module add_4 (
   input  logic       clk,
   input  logic       rst,
   output logic       cout,
   output logic [3:0] sum,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic       ovf
);

   // c[i] is the carry into bit i; c[4] is the carry out of the MSB.
   logic [4:0] c;
   logic [3:0] s;

   assign c[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      add_4_fa u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   // Signed overflow: carry into the sign bit disagrees with carry out of it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= 4'h0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         sum  <= s;
         cout <= c[4];
         ovf  <= c[3] ^ c[4];
      end
   end

endmodule

// File: tb/tb_add_4.sv
// Directed bench for add_4: reset, exhaustive cin=0 sweep, carry-in, overflow
// and mid-stream reset, each checked one cycle after the operands are applied.

module tb_add_4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cout;
   logic [3:0] sum;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       ovf;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [5:0] exp;  // {ovf, cout, sum}
   } vec_t;

   add_4 dut (
      .clk  (clk),
      .rst  (rst),
      .cout (cout),
      .sum  (sum),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   // Drive operands on the falling edge, then sample just after the next rising edge.
   task automatic step(input logic r, input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
      @(negedge clk);
      rst = r;
      a   = ta;
      b   = tb_v;
      cin = tc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 4'hF, 4'hF, 1'b1);
      vectors++;
      if ({ovf, cout, sum} !== 6'b000000) begin
         miscompares++;
         $display("FAIL reset_cycle1: got %b want %b", {ovf, cout, sum}, 6'b000000);
      end
      step(1'b1, 4'hF, 4'hF, 1'b1);
      vectors++;
      if ({ovf, cout, sum} !== 6'b000000) begin
         miscompares++;
         $display("FAIL reset_cycle2: got %b want %b", {ovf, cout, sum}, 6'b000000);
      end
      step(1'b0, 4'hF, 4'hF, 1'b1);
      vectors++;
      if ({ovf, cout, sum} !== 6'b011111) begin
         miscompares++;
         $display("FAIL reset_release: got %b want %b", {ovf, cout, sum}, 6'b011111);
      end
   endtask

   task automatic test_sweep();
      logic [4:0] s5;
      logic [5:0] exp;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] iv;
         iv = 8'(i);
         step(1'b0, iv[7:4], iv[3:0], 1'b0);
         s5  = {1'b0, iv[7:4]} + {1'b0, iv[3:0]};
         exp = {(iv[7] == iv[3]) && (s5[3] != iv[7]), s5};
         vectors++;
         if ({ovf, cout, sum} !== exp) begin
            miscompares++;
            $display("FAIL sweep a=%0d b=%0d: got %b want %b", iv[7:4], iv[3:0], {ovf, cout, sum}, exp);
         end
      end
   endtask

   task automatic test_checkpoints();
      vec_t v [3] = '{
         '{4'd0,  4'd0,  1'b0, 6'b000000},
         '{4'd3,  4'd5,  1'b0, 6'b101000},
         '{4'd15, 4'd15, 1'b0, 6'b011110}
      };
      foreach (v[i]) begin
         step(1'b0, v[i].a, v[i].b, v[i].cin);
         vectors++;
         if ({ovf, cout, sum} !== v[i].exp) begin
            miscompares++;
            $display("FAIL checkpoint %0d: got %b want %b", i, {ovf, cout, sum}, v[i].exp);
         end
      end
   endtask

   task automatic test_carry_in();
      vec_t v [2] = '{
         '{4'd15, 4'd0, 1'b1, 6'b010000},
         '{4'd0,  4'd0, 1'b1, 6'b000001}
      };
      foreach (v[i]) begin
         step(1'b0, v[i].a, v[i].b, v[i].cin);
         vectors++;
         if ({ovf, cout, sum} !== v[i].exp) begin
            miscompares++;
            $display("FAIL carry_in %0d: got %b want %b", i, {ovf, cout, sum}, v[i].exp);
         end
      end
   endtask

   task automatic test_overflow();
      vec_t v [4] = '{
         '{4'd7,  4'd1,  1'b0, 6'b101000},
         '{4'd8,  4'd8,  1'b0, 6'b110000},
         '{4'd15, 4'd1,  1'b0, 6'b010000},
         '{4'd8,  4'd15, 1'b0, 6'b110111}
      };
      foreach (v[i]) begin
         step(1'b0, v[i].a, v[i].b, v[i].cin);
         vectors++;
         if ({ovf, cout, sum} !== v[i].exp) begin
            miscompares++;
            $display("FAIL overflow %0d: got %b want %b", i, {ovf, cout, sum}, v[i].exp);
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic r [5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vec_t v [5] = '{
         '{4'd2,  4'd3, 1'b0, 6'b000101},
         '{4'd9,  4'd4, 1'b1, 6'b001110},
         '{4'd6,  4'd6, 1'b0, 6'b000000},
         '{4'd4,  4'd4, 1'b1, 6'b101001},
         '{4'd12, 4'd5, 1'b0, 6'b010001}
      };
      foreach (v[i]) begin
         step(r[i], v[i].a, v[i].b, v[i].cin);
         vectors++;
         if ({ovf, cout, sum} !== v[i].exp) begin
            miscompares++;
            $display("FAIL reset_midstream %0d: got %b want %b", i, {ovf, cout, sum}, v[i].exp);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      a   = 4'h0;
      b   = 4'h0;
      cin = 1'b0;
      test_reset();
      test_sweep();
      test_checkpoints();
      test_carry_in();
      test_overflow();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
